dcache_refill_ctrl: RTL and testbench
=====================================

DCACHE_REFILL_CTRL -- requirements
Module: dcache_refill_ctrl

Interface
REQ-001 clk  in  1  single clock, all state updates on posedge clk.
REQ-002 rst  in  1  asynchronous, active-high reset.
REQ-003 cpu_rd_req  in  1  load in MEM stage; cpu_rd_addr  in  32  byte address, held stable by CPU while stall=1.
REQ-004 cache_hit  in  1  dcache hit for cpu_rd_addr, covering both words when addr[1:0]!=0.
REQ-005 cpu_wr_req  in  1; cpu_wr_addr  in  32; cpu_wr_data  in  32  write-through store.
REQ-006 stall  out  1  freeze pipeline; rd_data  out  32  refilled load data; rd_data_valid  out  1.
REQ-007 fill_en  out  1; fill_addr  out  32; fill_data  out  64  refill to dcache, low word at aligned address, high word at aligned+4.
REQ-008 mem_req_valid  out  1; mem_req_ready  in  1; mem_req_we  out  1; mem_req_addr  out  32; mem_req_wdata  out  32.
REQ-009 mem_rsp_valid  in  1; mem_rsp_data  in  32  read response, in order, one outstanding; writes return no response.

Function
REQ-010 FSM states: IDLE, REQ1, RSP1, REQ2, RSP2, FILL, WR.
- IDLE->WR: write buffer non-empty; drain takes priority over a read miss.
- IDLE->REQ1: buffer empty and cpu_rd_req && !cache_hit.
REQ-011 REQ1 drives mem_req_valid=1, we=0, addr={cpu_rd_addr[31:2],2'b00}. Leaves for RSP1 on mem_req_ready.
REQ-012 RSP1 captures word1 on mem_rsp_valid.
- Goes to REQ2 if cpu_rd_addr[1:0]!=0, else FILL.
- REQ2/RSP2 fetch the aligned address + 4 (32-bit wrap from 0xFFFFFFFC to 0x0), then go to FILL.
REQ-013 mem_req_* are held stable while mem_req_valid && !mem_req_ready.
REQ-014 mem_req_valid is registered: asserted the cycle after the state is entered.
REQ-015 FILL lasts exactly one cycle and returns to IDLE.
- fill_en=1, fill_addr=cpu_rd_addr, fill_data={word2,word1}; word2=0 when aligned.
- rd_data_valid=1 in the same cycle.
REQ-016 rd_data merge:
- offset 0: word1
- offset 1: {word2[7:0], word1[31:8]}
- offset 2: {word2[15:0], word1[31:16]}
- offset 3: {word2[23:0], word1[31:24]}
REQ-017 stall is combinational; it is 1 when either condition holds:
- (cpu_rd_req && !cache_hit && state!=FILL)
- (cpu_wr_req && buffer full && no pop this cycle).
REQ-018 Minimum miss latency, zero-wait memory, aligned: miss at T, REQ1 at T+1, RSP1 at T+2, FILL at T+3.
REQ-019 cpu_wr_req with no stall pushes {addr,data} into the write buffer.
- Push and pop in the same cycle are both honoured.
- A write never updates the cache here; dcache handles write hits itself.
REQ-020 WR drives the buffer head with we=1 and pops on mem_req_ready. It returns to IDLE after each pop, so a read miss waits until the buffer is empty.
REQ-021 cpu_rd_req dropping mid-refill does not abort it: FILL still occurs.

Reset
REQ-022 Asynchronous rst forces outputs and state immediately.
- Outputs: state=IDLE, stall=0 (combinational inputs permitting), rd_data=0, rd_data_valid=0, fill_en=0, fill_addr=0, fill_data=0, mem_req_valid=0, mem_req_we=0, mem_req_addr=0, mem_req_wdata=0.
- Write buffer: empty.
REQ-023 Reset mid-transaction discards captured words and buffered stores. A late mem_rsp_valid arriving in IDLE is ignored.

Configuration
REQ-024 Macro DCACHE_WBUF_EN.
- Defined: the write buffer is a 2-entry FIFO (full at 2 entries).
- Undefined: there is no buffer. cpu_wr_req in IDLE goes directly to WR, and stall=1 from the request until the cycle mem_req_ready accepts the write.

Verification
REQ-025 Aligned miss: rd_addr=0x100, rsp=0xDEADBEEF after 2 wait cycles -> one mem read at 0x100; fill_en with fill_data=0x00000000_DEADBEEF; rd_data=0xDEADBEEF; stall low in the FILL cycle.
REQ-026 Misaligned miss: rd_addr=0x203, words 0x44332211 and 0x88776655 -> reads at 0x200 then 0x204; rd_data=0x77665544.
REQ-027 Backpressure: mem_req_ready=0 for 5 cycles during REQ1 -> mem_req_addr/valid stable for all 5 cycles; a single request is accepted.
REQ-028 Ordering (DCACHE_WBUF_EN): stores to 0x10 and 0x14, then a miss at 0x10 -> both writes issued before the read; a third store while full stalls one or more cycles.
REQ-029 Async rst asserted in RSP1 -> mem_req_valid=0 and fill_en=0 immediately; a subsequent stray mem_rsp_valid causes no fill_en.
REQ-030 Wrap: rd_addr=0xFFFFFFFE miss -> second read address 0x00000000.

Source files
------------

// File: rtl/dcache_refill_ctrl.sv
// Data-cache miss refill controller with write-through store path.
// Optional 2-entry store buffer is enabled by defining DCACHE_WBUF_EN.
module dcache_refill_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_rd_req,
  input  logic [31:0] cpu_rd_addr,
  input  logic        cache_hit,
  input  logic        cpu_wr_req,
  input  logic [31:0] cpu_wr_addr,
  input  logic [31:0] cpu_wr_data,
  output logic        stall,
  output logic [31:0] rd_data,
  output logic        rd_data_valid,
  output logic        fill_en,
  output logic [31:0] fill_addr,
  output logic [63:0] fill_data,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_we,
  output logic [31:0] mem_req_addr,
  output logic [31:0] mem_req_wdata,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ1 = 3'd1,
    ST_RSP1 = 3'd2,
    ST_REQ2 = 3'd3,
    ST_RSP2 = 3'd4,
    ST_FILL = 3'd5,
    ST_WR   = 3'd6
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic [31:0] miss_addr_r;
  logic [31:0] word1_r;
  logic [31:0] word2_r;
  logic [31:0] word1_s;
  logic [31:0] word2_s;
  logic        pop_s;
  logic        wr_pending_s;
  logic        wr_block_s;
  logic [31:0] wr_head_addr_s;
  logic [31:0] wr_head_data_s;

  // Merged load data: the misaligned word straddles word1 (low) and word2 (high).
  function automatic logic [31:0] merge_word(input logic [31:0] w1,
                                             input logic [31:0] w2,
                                             input logic [1:0]  ofs);
    return 32'({w2, w1} >> {ofs, 3'b000});
  endfunction

  assign pop_s = (state_r == ST_WR) && mem_req_valid && mem_req_ready;

`ifdef DCACHE_WBUF_EN
  logic [31:0] wb_addr_r [2];
  logic [31:0] wb_data_r [2];
  logic        wb_rd_ptr_r;
  logic        wb_wr_ptr_r;
  logic [1:0]  wb_count_r;
  logic        push_s;

  assign push_s         = cpu_wr_req && !stall;
  assign wr_pending_s   = (wb_count_r != 2'd0);
  assign wr_block_s     = cpu_wr_req && (wb_count_r == 2'd2) && !pop_s;
  assign wr_head_addr_s = wb_addr_r[wb_rd_ptr_r];
  assign wr_head_data_s = wb_data_r[wb_rd_ptr_r];

  // Store buffer storage, pointers and occupancy (push and pop may coincide)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        wb_addr_r[i] <= 32'd0;
        wb_data_r[i] <= 32'd0;
      end
      wb_rd_ptr_r <= 1'b0;
      wb_wr_ptr_r <= 1'b0;
      wb_count_r  <= 2'd0;
    end else begin
      if (push_s) begin
        wb_addr_r[wb_wr_ptr_r] <= cpu_wr_addr;
        wb_data_r[wb_wr_ptr_r] <= cpu_wr_data;
        wb_wr_ptr_r            <= ~wb_wr_ptr_r;
      end
      if (pop_s) begin
        wb_rd_ptr_r <= ~wb_rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   wb_count_r <= wb_count_r + 2'd1;
        2'b01:   wb_count_r <= wb_count_r - 2'd1;
        default: wb_count_r <= wb_count_r;
      endcase
    end
  end
`else
  // Without a buffer the store itself is the pending write; the CPU holds it under stall.
  assign wr_pending_s   = cpu_wr_req;
  assign wr_block_s     = cpu_wr_req && !pop_s;
  assign wr_head_addr_s = cpu_wr_addr;
  assign wr_head_data_s = cpu_wr_data;
`endif

  assign stall = (cpu_rd_req && !cache_hit && (state_r != ST_FILL)) || wr_block_s;

  // Response capture view used both for the word registers and the fill outputs
  always_comb begin
    word1_s = word1_r;
    word2_s = word2_r;
    if ((state_r == ST_RSP1) && mem_rsp_valid) begin
      word1_s = mem_rsp_data;
    end else if ((state_r == ST_RSP2) && mem_rsp_valid) begin
      word2_s = mem_rsp_data;
    end else begin
      word1_s = word1_r;
    end
  end

  // Next-state logic; pending writes drain before any read miss is serviced
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (wr_pending_s) begin
          state_s = ST_WR;
        end else if (cpu_rd_req && !cache_hit) begin
          state_s = ST_REQ1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_REQ1: begin
        if (mem_req_valid && mem_req_ready) begin
          state_s = ST_RSP1;
        end else begin
          state_s = ST_REQ1;
        end
      end
      ST_RSP1: begin
        if (mem_rsp_valid) begin
          state_s = (miss_addr_r[1:0] != 2'b00) ? ST_REQ2 : ST_FILL;
        end else begin
          state_s = ST_RSP1;
        end
      end
      ST_REQ2: begin
        if (mem_req_valid && mem_req_ready) begin
          state_s = ST_RSP2;
        end else begin
          state_s = ST_REQ2;
        end
      end
      ST_RSP2: begin
        if (mem_rsp_valid) begin
          state_s = ST_FILL;
        end else begin
          state_s = ST_RSP2;
        end
      end
      ST_FILL: state_s = ST_IDLE;
      ST_WR: begin
        if (pop_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_WR;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Miss address and captured words; the miss address is latched so a dropped load still fills
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      miss_addr_r <= 32'd0;
      word1_r     <= 32'd0;
      word2_r     <= 32'd0;
    end else if ((state_r == ST_IDLE) && (state_s == ST_REQ1)) begin
      miss_addr_r <= cpu_rd_addr;
      word1_r     <= 32'd0;
      word2_r     <= 32'd0;
    end else begin
      word1_r <= word1_s;
      word2_r <= word2_s;
    end
  end

  // Memory request registers: loaded on state entry, held while waiting for ready
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req_valid <= 1'b0;
      mem_req_we    <= 1'b0;
      mem_req_addr  <= 32'd0;
      mem_req_wdata <= 32'd0;
    end else begin
      mem_req_valid <= (state_s inside {ST_REQ1, ST_REQ2, ST_WR});
      if (state_s != state_r) begin
        case (state_s)
          ST_REQ1: begin
            mem_req_we    <= 1'b0;
            mem_req_addr  <= {cpu_rd_addr[31:2], 2'b00};
            mem_req_wdata <= 32'd0;
          end
          ST_REQ2: begin
            mem_req_we    <= 1'b0;
            mem_req_addr  <= {miss_addr_r[31:2], 2'b00} + 32'd4;
            mem_req_wdata <= 32'd0;
          end
          ST_WR: begin
            mem_req_we    <= 1'b1;
            mem_req_addr  <= wr_head_addr_s;
            mem_req_wdata <= wr_head_data_s;
          end
          default: begin
            mem_req_we    <= mem_req_we;
            mem_req_addr  <= mem_req_addr;
            mem_req_wdata <= mem_req_wdata;
          end
        endcase
      end
    end
  end

  // Fill and load-return outputs, valid for exactly the FILL cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_en       <= 1'b0;
      rd_data_valid <= 1'b0;
      fill_addr     <= 32'd0;
      fill_data     <= 64'd0;
      rd_data       <= 32'd0;
    end else begin
      fill_en       <= (state_s == ST_FILL);
      rd_data_valid <= (state_s == ST_FILL);
      if (state_s == ST_FILL) begin
        fill_addr <= miss_addr_r;
        fill_data <= {word2_s, word1_s};
        rd_data   <= merge_word(word1_s, word2_s, miss_addr_r[1:0]);
      end
    end
  end

endmodule

// File: tb/tb_dcache_refill_ctrl.sv
// Directed self-checking bench for dcache_refill_ctrl (default build, buffered build via DCACHE_WBUF_EN).
module tb_dcache_refill_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_rd_req, cache_hit, cpu_wr_req;
  logic [31:0] cpu_rd_addr, cpu_wr_addr, cpu_wr_data;
  logic        stall, rd_data_valid, fill_en;
  logic [31:0] rd_data, fill_addr;
  logic [63:0] fill_data;
  logic        mem_req_valid, mem_req_ready, mem_req_we;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;

  int          n_assert = 0;
  int          n_fail = 0;
  logic [32:0] acc_q[$];

  dcache_refill_ctrl dut (
    .clk(clk), .rst(rst),
    .cpu_rd_req(cpu_rd_req), .cpu_rd_addr(cpu_rd_addr), .cache_hit(cache_hit),
    .cpu_wr_req(cpu_wr_req), .cpu_wr_addr(cpu_wr_addr), .cpu_wr_data(cpu_wr_data),
    .stall(stall), .rd_data(rd_data), .rd_data_valid(rd_data_valid),
    .fill_en(fill_en), .fill_addr(fill_addr), .fill_data(fill_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data)
  );

  always #5 clk = ~clk;

  // Log of accepted memory requests as {we, addr}
  always @(posedge clk) begin
    if (!rst && mem_req_valid && mem_req_ready) acc_q.push_back({mem_req_we, mem_req_addr});
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cpu_rd_req = 1'b0; cache_hit = 1'b0; cpu_wr_req = 1'b0;
    cpu_rd_addr = 32'd0; cpu_wr_addr = 32'd0; cpu_wr_data = 32'd0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = 32'd0;
    cyc(); cyc(); #1;
    chk("rst_stall", stall, 0);
    chk("rst_req_valid", mem_req_valid, 0);
    chk("rst_req_we", mem_req_we, 0);
    chk("rst_req_addr", mem_req_addr, 0);
    chk("rst_fill_en", fill_en, 0);
    chk("rst_fill_data", fill_data, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_rd_valid", rd_data_valid, 0);
    #2 rst = 1'b0;

    // Aligned miss at 0x100, response after two wait cycles
    cyc(); cpu_rd_req = 1'b1; cpu_rd_addr = 32'h100; mem_req_ready = 1'b1; #1;
    chk("al_stall_miss", stall, 1);
    cyc(); #1;
    chk("al_req_valid", mem_req_valid, 1);
    chk("al_req_addr", mem_req_addr, 32'h100);
    chk("al_req_we", mem_req_we, 0);
    cyc(); #1;
    chk("al_rsp1_valid_low", mem_req_valid, 0);
    chk("al_rsp1_stall", stall, 1);
    cyc();
    cyc(); mem_rsp_valid = 1'b1; mem_rsp_data = 32'hDEADBEEF; #1;
    chk("al_no_fill_yet", fill_en, 0);
    cyc(); mem_rsp_valid = 1'b0; #1;
    chk("al_fill_en", fill_en, 1);
    chk("al_fill_addr", fill_addr, 32'h100);
    chk("al_fill_data", fill_data, 64'h00000000_DEADBEEF);
    chk("al_rd_data", rd_data, 32'hDEADBEEF);
    chk("al_rd_valid", rd_data_valid, 1);
    chk("al_fill_stall", stall, 0);
    cpu_rd_req = 1'b0;
    cyc(); #1;
    chk("al_fill_done", fill_en, 0);
    chk("al_nreq", acc_q.size(), 1);
    chk("al_req0", acc_q[0], {1'b0, 32'h100});
    acc_q.delete();

    // Zero-wait aligned miss: REQ1 at T+1, FILL at T+3; response held high in IDLE is ignored
    cyc(); cpu_rd_req = 1'b1; cpu_rd_addr = 32'h300; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0BADF00D; #1;
    chk("zw_t0_valid", mem_req_valid, 0);
    cyc(); #1;
    chk("zw_t1_valid", mem_req_valid, 1);
    cyc(); #1;
    chk("zw_t2_fill", fill_en, 0);
    cyc(); mem_rsp_valid = 1'b0; #1;
    chk("zw_t3_fill", fill_en, 1);
    chk("zw_rd_data", rd_data, 32'h0BADF00D);
    cpu_rd_req = 1'b0;
    cyc(); acc_q.delete();

    // Misaligned miss at 0x203
    cyc(); cpu_rd_req = 1'b1; cpu_rd_addr = 32'h203; #1;
    cyc(); #1;
    chk("ma_req1_addr", mem_req_addr, 32'h200);
    cyc(); mem_rsp_valid = 1'b1; mem_rsp_data = 32'h44332211; #1;
    cyc(); mem_rsp_valid = 1'b0; #1;
    chk("ma_req2_valid", mem_req_valid, 1);
    chk("ma_req2_addr", mem_req_addr, 32'h204);
    cyc(); mem_rsp_valid = 1'b1; mem_rsp_data = 32'h88776655; #1;
    chk("ma_rsp2_stall", stall, 1);
    cyc(); mem_rsp_valid = 1'b0; #1;
    chk("ma_fill_en", fill_en, 1);
    chk("ma_rd_data", rd_data, 32'h77665544);
    chk("ma_fill_data", fill_data, 64'h88776655_44332211);
    chk("ma_fill_addr", fill_addr, 32'h203);
    cpu_rd_req = 1'b0;
    cyc(); #1;
    chk("ma_nreq", acc_q.size(), 2);
    chk("ma_req0", acc_q[0], {1'b0, 32'h200});
    chk("ma_req1", acc_q[1], {1'b0, 32'h204});
    acc_q.delete();

    // Wrap at top of address space; load request dropped mid-refill still fills
    cyc(); cpu_rd_req = 1'b1; cpu_rd_addr = 32'hFFFFFFFE; #1;
    cyc(); #1;
    chk("wr_req1_addr", mem_req_addr, 32'hFFFFFFFC);
    cyc(); mem_rsp_valid = 1'b1; mem_rsp_data = 32'hAABBCCDD; cpu_rd_req = 1'b0; #1;
    chk("wr_drop_stall", stall, 0);
    cyc(); mem_rsp_valid = 1'b0; #1;
    chk("wr_req2_addr", mem_req_addr, 32'h0);
    cyc(); mem_rsp_valid = 1'b1; mem_rsp_data = 32'h11223344; #1;
    cyc(); mem_rsp_valid = 1'b0; #1;
    chk("wr_fill_en", fill_en, 1);
    chk("wr_rd_data", rd_data, 32'h3344AABB);
    chk("wr_fill_addr", fill_addr, 32'hFFFFFFFE);
    cyc(); acc_q.delete();

    // Backpressure: ready low for five REQ1 cycles
    cyc(); cpu_rd_req = 1'b1; cpu_rd_addr = 32'h400; mem_req_ready = 1'b0; #1;
    for (int i = 0; i < 5; i++) begin
      cyc(); #1;
      chk("bp_hold_valid", mem_req_valid, 1);
      chk("bp_hold_addr", mem_req_addr, 32'h400);
    end
    cyc(); mem_req_ready = 1'b1; #1;
    chk("bp_acc_addr", mem_req_addr, 32'h400);
    cyc(); mem_rsp_valid = 1'b1; mem_rsp_data = 32'h55AA55AA; #1;
    chk("bp_rsp1_valid", mem_req_valid, 0);
    cyc(); mem_rsp_valid = 1'b0; #1;
    chk("bp_rd_data", rd_data, 32'h55AA55AA);
    cpu_rd_req = 1'b0;
    cyc(); #1;
    chk("bp_nreq", acc_q.size(), 1);
    acc_q.delete();

`ifdef DCACHE_WBUF_EN
    // Two buffered stores, a third that stalls while full, then a miss that waits for the drain
    cyc(); mem_req_ready = 1'b0; cpu_wr_req = 1'b1; cpu_wr_addr = 32'h10; cpu_wr_data = 32'hA0; #1;
    chk("wb_push1_stall", stall, 0);
    cyc(); cpu_wr_addr = 32'h14; cpu_wr_data = 32'hB0; #1;
    chk("wb_push2_stall", stall, 0);
    cyc(); cpu_wr_addr = 32'h18; cpu_wr_data = 32'hC0; #1;
    chk("wb_full_stall", stall, 1);
    chk("wb_head_addr", mem_req_addr, 32'h10);
    chk("wb_head_we", mem_req_we, 1);
    cyc(); mem_req_ready = 1'b1; #1;
    chk("wb_pop_stall", stall, 0);
    cyc(); cpu_wr_req = 1'b0; cpu_rd_req = 1'b1; cpu_rd_addr = 32'h10;
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h600DCAFE; #1;
    chk("wb_miss_stall", stall, 1);
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
        cyc(); #1;
        if (fill_en) seen = 1'b1;
      end
      chk("wb_fill_seen", seen, 1);
    end
    chk("wb_rd_data", rd_data, 32'h600DCAFE);
    cpu_rd_req = 1'b0; mem_rsp_valid = 1'b0;
    cyc(); #1;
    chk("wb_nreq", acc_q.size(), 4);
    chk("wb_ord0", acc_q[0], {1'b1, 32'h10});
    chk("wb_ord1", acc_q[1], {1'b1, 32'h14});
    chk("wb_ord2", acc_q[2], {1'b1, 32'h18});
    chk("wb_ord3", acc_q[3], {1'b0, 32'h10});
    acc_q.delete();
`else
    // Unbuffered store: stall from request until the write is accepted
    cyc(); mem_req_ready = 1'b0; cpu_wr_req = 1'b1; cpu_wr_addr = 32'h10; cpu_wr_data = 32'hCAFE0001; #1;
    chk("st_stall_idle", stall, 1);
    cyc(); #1;
    chk("st_valid", mem_req_valid, 1);
    chk("st_we", mem_req_we, 1);
    chk("st_addr", mem_req_addr, 32'h10);
    chk("st_wdata", mem_req_wdata, 32'hCAFE0001);
    chk("st_stall_wait", stall, 1);
    cyc(); mem_req_ready = 1'b1; #1;
    chk("st_stall_acc", stall, 0);
    cyc(); cpu_wr_req = 1'b0; #1;
    chk("st_done_valid", mem_req_valid, 0);
    chk("st_nreq", acc_q.size(), 1);
    chk("st_req0", acc_q[0], {1'b1, 32'h10});
    acc_q.delete();
`endif

    // Async reset while a request is pending drops valid without a clock edge
    cyc(); cpu_rd_req = 1'b1; cpu_rd_addr = 32'h500; mem_req_ready = 1'b0; #1;
    cyc(); #1;
    chk("ra_valid_before", mem_req_valid, 1);
    #1 rst = 1'b1; #1;
    chk("ra_valid_async", mem_req_valid, 0);
    chk("ra_addr_async", mem_req_addr, 0);
    cpu_rd_req = 1'b0;
    #2 rst = 1'b0;

    // Async reset in RSP1, then a stray response must not fill
    cyc(); cpu_rd_req = 1'b1; cpu_rd_addr = 32'h600; mem_req_ready = 1'b1; #1;
    cyc(); #1;
    chk("rb_req_addr", mem_req_addr, 32'h600);
    cyc(); #1;
    rst = 1'b1; #1;
    chk("rb_valid", mem_req_valid, 0);
    chk("rb_fill_en", fill_en, 0);
    chk("rb_addr", mem_req_addr, 0);
    cpu_rd_req = 1'b0;
    #2 rst = 1'b0;
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0000BAD0;
    for (int i = 0; i < 3; i++) begin
      cyc(); #1;
      chk("rb_stray_fill", fill_en, 0);
      chk("rb_stray_rdv", rd_data_valid, 0);
      chk("rb_stray_req", mem_req_valid, 0);
    end
    mem_rsp_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
